calc_key_entry: RTL and testbench

Keypad-side controller of the BCD calculator: the producer of the ALU's operand and operator inputs and the consumer of its result. It accepts one key code per handshake, assembles two 4-digit BCD operands, and drives `bcd1`, `bcd2` and `op_selected` into the ALU. On `=` it latches the ALU's `bcd_out` and `special_signal` into a result register and presents operand, operator or result on a display bus.

---
 rtl/calc_pkg.sv | 9 +
 rtl/bcd_digit_shift.sv | 31 +++
 rtl/calc_key_entry.sv | 82 ++++++++
 tb/tb_calc_key_entry.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator encodings and entry FSM states shared by the calculator keypad logic
package calc_pkg;
  localparam logic [3:0] KEY_ADD = 4'hA, KEY_SUB = 4'hB, KEY_EQ = 4'hC, KEY_CE = 4'hD, KEY_AC = 4'hE;
  localparam logic [1:0] OP_NONE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10;
  typedef enum logic [1:0] {S_OP1 = 2'd0, S_OP2 = 2'd1, S_CALC = 2'd2, S_RESULT = 2'd3} state_t;
  function automatic logic [1:0] key_op(input logic [3:0] k);
    return k == KEY_SUB ? OP_SUB : OP_ADD;
  endfunction
endpackage

// File: rtl/bcd_digit_shift.sv
// bcd_digit_shift: 4-digit BCD operand register with digit counter; clear beats load beats shift-in
module bcd_digit_shift #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        clr,
  input  logic        ld,
  input  logic [15:0] ld_val,
  input  logic [2:0]  ld_cnt,
  input  logic        shift,
  input  logic [3:0]  digit,
  output logic [15:0] val,
  output logic [2:0]  cnt
);
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      val <= '0;
      cnt <= '0;
    end else if (clr) begin
      val <= '0;
      cnt <= '0;
    end else if (ld) begin
      val <= ld_val;
      cnt <= ld_cnt;
    end else if (shift && cnt < MAX_CNT) begin
      val <= {val[11:0], digit};
      cnt <= cnt + 3'd1;
    end
endmodule

// File: rtl/calc_key_entry.sv
// calc_key_entry: keypad entry FSM assembling two BCD operands for the ALU and latching its result
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic [3:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [15:0] alu_bcd_out,
  input  logic        alu_special,
  output logic [15:0] bcd1,
  output logic [15:0] bcd2,
  output logic [1:0]  op_selected,
  output logic [15:0] disp_bcd,
  output logic        disp_neg,
  output logic [1:0]  entry_state
);
  state_t      state;
  logic [15:0] res_bcd;
  logic        res_neg;
  logic [2:0]  cnt1, cnt2, cnt;
  logic        acc, is_dig, is_op, res_go, full_clr;
  logic        b1_clr, b1_ld, b1_shift, b2_clr, b2_shift;
  assign key_ready = state != S_CALC;
  assign acc = key_valid && key_ready;
  assign is_dig = key_code <= 4'd9;
  assign is_op = key_code == KEY_ADD || key_code == KEY_SUB;
  // a negative result cannot seed a new operand, so only digits or operators on a positive result leave S_RESULT
  assign res_go = acc && state == S_RESULT && (is_dig || (is_op && !res_neg));
  assign full_clr = acc && (key_code == KEY_AC || (state == S_RESULT && key_code == KEY_CE));
  assign b1_clr = full_clr || (acc && state == S_OP1 && key_code == KEY_CE);
  assign b1_ld = res_go;
  assign b1_shift = acc && state == S_OP1 && is_dig;
  assign b2_clr = full_clr || res_go || (acc && ((state == S_OP2 && key_code == KEY_CE) || (state == S_OP1 && is_op)));
  assign b2_shift = acc && state == S_OP2 && is_dig;
  bcd_digit_shift #(.MAX_DIGITS(MAX_DIGITS)) u_op1 (
    .clk(clk), .clear_n(clear_n), .clr(b1_clr), .ld(b1_ld),
    .ld_val(is_dig ? {12'h000, key_code} : res_bcd), .ld_cnt(is_dig ? 3'd1 : 3'd0),
    .shift(b1_shift), .digit(key_code), .val(bcd1), .cnt(cnt1)
  );
  bcd_digit_shift #(.MAX_DIGITS(MAX_DIGITS)) u_op2 (
    .clk(clk), .clear_n(clear_n), .clr(b2_clr), .ld(1'b0),
    .ld_val(16'h0000), .ld_cnt(3'd0),
    .shift(b2_shift), .digit(key_code), .val(bcd2), .cnt(cnt2)
  );
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      state <= S_OP1;
      op_selected <= OP_NONE;
      res_bcd <= '0;
      res_neg <= 1'b0;
    end else if (full_clr) begin
      state <= S_OP1;
      op_selected <= OP_NONE;
      res_bcd <= '0;
      res_neg <= 1'b0;
    end else if (state == S_CALC) begin
      res_bcd <= alu_bcd_out;
      res_neg <= alu_special;
      state <= S_RESULT;
    end else if (acc) begin
      case (state)
        S_OP1: if (is_op) begin
          op_selected <= key_op(key_code);
          state <= S_OP2;
        end
        S_OP2: if (is_op) op_selected <= key_op(key_code);
          else if (key_code == KEY_EQ) state <= S_CALC;
        default: if (res_go) begin
          op_selected <= is_dig ? OP_NONE : key_op(key_code);
          state <= is_dig ? S_OP1 : S_OP2;
        end
      endcase
    end
  assign cnt = state == S_OP1 ? cnt1 : cnt2;
  assign disp_bcd = state == S_OP1 ? bcd1 : state == S_OP2 ? (cnt != 3'd0 ? bcd2 : bcd1) : res_bcd;
  assign disp_neg = state[1] && res_neg;
  assign entry_state = state;
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: table-driven key sequences with a BCD ALU model in the loop, plus CALC-cycle corner cases
module tb_calc_key_entry;
  import calc_pkg::*;
  logic        clk = 1'b0, clear_n = 1'b0, key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_ready, disp_neg, alu_special;
  logic [15:0] bcd1, bcd2, disp_bcd, alu_bcd_out;
  logic [1:0]  op_selected, entry_state;
  int          total = 0, bad = 0, alu_a, alu_b, low;

  calc_key_entry dut (
    .clk(clk), .clear_n(clear_n), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .alu_bcd_out(alu_bcd_out), .alu_special(alu_special),
    .bcd1(bcd1), .bcd2(bcd2), .op_selected(op_selected), .disp_bcd(disp_bcd),
    .disp_neg(disp_neg), .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  function automatic int b2i(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic logic [15:0] i2b(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  always_comb begin
    alu_a = b2i(bcd1);
    alu_b = b2i(bcd2);
    alu_special = op_selected == OP_SUB && alu_b > alu_a;
    alu_bcd_out = i2b(op_selected == OP_SUB ? (alu_b > alu_a ? alu_b - alu_a : alu_a - alu_b) : alu_a + alu_b);
  end

  typedef struct {
    logic [3:0]  key;
    int          extra;
    logic [15:0] b1, b2;
    logic [1:0]  op;
    logic [15:0] disp;
    logic        neg;
    logic [1:0]  st;
  } vec_t;
  vec_t v[$];

  function automatic void add(input logic [3:0] k, input int e, input logic [15:0] b1, input logic [15:0] b2,
                              input logic [1:0] op, input logic [15:0] d, input logic n, input logic [1:0] s);
    vec_t t;
    t.key = k; t.extra = e; t.b1 = b1; t.b2 = b2; t.op = op; t.disp = d; t.neg = n; t.st = s;
    v.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_code = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] b1, input logic [15:0] b2, input logic [1:0] op,
                         input logic [15:0] d, input logic n, input logic [1:0] s);
    chk({tag, " bcd1"}, bcd1, b1);
    chk({tag, " bcd2"}, bcd2, b2);
    chk({tag, " op_selected"}, 16'(op_selected), 16'(op));
    chk({tag, " disp_bcd"}, disp_bcd, d);
    chk({tag, " disp_neg"}, 16'(disp_neg), 16'(n));
    chk({tag, " entry_state"}, 16'(entry_state), 16'(s));
  endtask

  initial begin
    add(4'h1, 0, 16'h0001, 16'h0000, 2'b00, 16'h0001, 0, 2'd0);
    add(4'h2, 0, 16'h0012, 16'h0000, 2'b00, 16'h0012, 0, 2'd0);
    add(4'hA, 0, 16'h0012, 16'h0000, 2'b01, 16'h0012, 0, 2'd1);
    add(4'h3, 0, 16'h0012, 16'h0003, 2'b01, 16'h0003, 0, 2'd1);
    add(4'h4, 0, 16'h0012, 16'h0034, 2'b01, 16'h0034, 0, 2'd1);
    add(4'hC, 1, 16'h0012, 16'h0034, 2'b01, 16'h0046, 0, 2'd3);
    add(4'hA, 0, 16'h0046, 16'h0000, 2'b01, 16'h0046, 0, 2'd1);
    add(4'h1, 0, 16'h0046, 16'h0001, 2'b01, 16'h0001, 0, 2'd1);
    add(4'hC, 1, 16'h0046, 16'h0001, 2'b01, 16'h0047, 0, 2'd3);
    add(4'hE, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 2'd0);
    add(4'h5, 0, 16'h0005, 16'h0000, 2'b00, 16'h0005, 0, 2'd0);
    add(4'hB, 0, 16'h0005, 16'h0000, 2'b10, 16'h0005, 0, 2'd1);
    add(4'h1, 0, 16'h0005, 16'h0001, 2'b10, 16'h0001, 0, 2'd1);
    add(4'h2, 0, 16'h0005, 16'h0012, 2'b10, 16'h0012, 0, 2'd1);
    add(4'hC, 1, 16'h0005, 16'h0012, 2'b10, 16'h0007, 1, 2'd3);
    add(4'hA, 0, 16'h0005, 16'h0012, 2'b10, 16'h0007, 1, 2'd3);
    add(4'hD, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 2'd0);
    add(4'h1, 0, 16'h0001, 16'h0000, 2'b00, 16'h0001, 0, 2'd0);
    add(4'h2, 0, 16'h0012, 16'h0000, 2'b00, 16'h0012, 0, 2'd0);
    add(4'h3, 0, 16'h0123, 16'h0000, 2'b00, 16'h0123, 0, 2'd0);
    add(4'h4, 0, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 2'd0);
    add(4'h5, 0, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 2'd0);
    add(4'hD, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 2'd0);
    add(4'h9, 0, 16'h0009, 16'h0000, 2'b00, 16'h0009, 0, 2'd0);
    add(4'hC, 0, 16'h0009, 16'h0000, 2'b00, 16'h0009, 0, 2'd0);
    add(4'hF, 0, 16'h0009, 16'h0000, 2'b00, 16'h0009, 0, 2'd0);
    add(4'hA, 0, 16'h0009, 16'h0000, 2'b01, 16'h0009, 0, 2'd1);
    add(4'hB, 0, 16'h0009, 16'h0000, 2'b10, 16'h0009, 0, 2'd1);
    add(4'h7, 0, 16'h0009, 16'h0007, 2'b10, 16'h0007, 0, 2'd1);
    add(4'hD, 0, 16'h0009, 16'h0000, 2'b10, 16'h0009, 0, 2'd1);
    add(4'h8, 0, 16'h0009, 16'h0008, 2'b10, 16'h0008, 0, 2'd1);
    add(4'hC, 1, 16'h0009, 16'h0008, 2'b10, 16'h0001, 0, 2'd3);
    add(4'h3, 0, 16'h0003, 16'h0000, 2'b00, 16'h0003, 0, 2'd0);
    add(4'h4, 0, 16'h0034, 16'h0000, 2'b00, 16'h0034, 0, 2'd0);

    #1;
    chk_all("reset", 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0, 2'd0);
    chk("reset key_ready", 16'(key_ready), 16'h0001);
    @(negedge clk);
    clear_n = 1'b1;

    foreach (v[i]) begin
      press(v[i].key);
      repeat (v[i].extra) @(negedge clk);
      chk_all($sformatf("vec%0d", i), v[i].b1, v[i].b2, v[i].op, v[i].disp, v[i].neg, v[i].st);
    end

    press(KEY_ADD);
    press(4'h2);
    @(negedge clk);
    key_code = KEY_EQ;
    key_valid = 1'b1;
    low = 0;
    repeat (5) begin
      @(negedge clk);
      if (!key_ready) low++;
    end
    key_valid = 1'b0;
    chk("held valid ready-low cycles", 16'(low), 16'd1);
    chk_all("held valid", 16'h0034, 16'h0002, 2'b01, 16'h0036, 1'b0, 2'd3);

    press(KEY_ADD);
    press(4'h1);
    @(negedge clk);
    key_code = KEY_EQ;
    key_valid = 1'b1;
    @(negedge clk);
    chk("calc key_ready", 16'(key_ready), 16'h0000);
    key_code = 4'h5;
    @(negedge clk);
    key_valid = 1'b0;
    chk_all("calc drop", 16'h0036, 16'h0001, 2'b01, 16'h0037, 1'b0, 2'd3);

    press(KEY_ADD);
    press(4'h2);
    press(KEY_EQ);
    chk("pre-clear state", 16'(entry_state), 16'd2);
    #2 clear_n = 1'b0;
    #1;
    chk_all("async clear", 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0, 2'd0);
    chk("async clear key_ready", 16'(key_ready), 16'h0001);
    @(negedge clk);
    clear_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("after clear", 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
